// File: rtl/jtag_cmd_rx.sv
// Host-to-target command receiver for the JTAG UART debug link: sync hunt, opcode plus
// 40-bit little-endian payload, XOR checksum, local halt/step or valid/ack hand-off.
module jtag_cmd_rx #(
    parameter int          TIMEOUT_CYCLES = 25_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        CLK_50,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        CMD_VALID,
    output logic [7:0]  CMD_OP,
    output logic [39:0] CMD_DATA,
    input  logic        CMD_ACK,
    output logic        HALT,
    output logic        STEP,
    output logic        ERR_CSUM,
    output logic        ERR_TIMEOUT
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_HALT = 8'h01;
    localparam logic [7:0] OP_STEP = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_DATA,
        S_CSUM,
        S_PEND
    } state_t;

    state_t           state;
    logic [7:0]       op_q;
    logic [7:0]       xor_q;
    logic [39:0]      data_q;
    logic [2:0]       idx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;

    assign accept = RX_VALID && RX_READY;

    // NOTE: all state is updated with non-blocking assignments so every branch sees
    // the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state       <= S_IDLE;
            op_q        <= '0;
            xor_q       <= '0;
            data_q      <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            RX_READY    <= 1'b1;
            CMD_VALID   <= 1'b0;
            CMD_OP      <= '0;
            CMD_DATA    <= '0;
            HALT        <= 1'b0;
            STEP        <= 1'b0;
            ERR_CSUM    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            STEP        <= 1'b0;
            ERR_CSUM    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;

            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (accept && RX_DATA == SYNC_BYTE) begin
                        state <= S_OP;
                    end
                end

                S_OP, S_DATA, S_CSUM: begin
                    // An accepted byte beats the terminal count and restarts the gap timer.
                    if (accept) begin
                        tmo_cnt <= '0;
                        if (state == S_OP) begin
                            op_q  <= RX_DATA;
                            xor_q <= RX_DATA;
                            idx   <= '0;
                            state <= S_DATA;
                        end else if (state == S_DATA) begin
                            data_q[{idx, 3'b000} +: 8] <= RX_DATA;
                            xor_q <= xor_q ^ RX_DATA;
                            idx   <= idx + 3'd1;
                            if (idx == 3'd4) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            state <= S_IDLE;
                            if (RX_DATA != xor_q) begin
                                ERR_CSUM <= 1'b1;
                            end else if (op_q == OP_HALT) begin
                                HALT <= data_q[0];
                            end else if (op_q == OP_STEP) begin
                                STEP <= 1'b1;
                            end else begin
                                CMD_OP    <= op_q;
                                CMD_DATA  <= data_q;
                                CMD_VALID <= 1'b1;
                                RX_READY  <= 1'b0;
                                state     <= S_PEND;
                            end
                        end
                    end else if (tmo_cnt >= CNT_TERM) begin
                        tmo_cnt     <= '0;
                        ERR_TIMEOUT <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_PEND: begin
                    tmo_cnt <= '0;
                    if (CMD_ACK) begin
                        CMD_VALID <= 1'b0;
                        RX_READY  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    RX_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_cmd_rx.sv
// Scoreboard bench for jtag_cmd_rx: stimulus pushes expected events, a negedge monitor
// pops and compares each command, halt change, step, and error pulse it observes.
module tb_jtag_cmd_rx;

    logic        CLK_50;
    logic        RESET;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        CMD_VALID;
    logic [7:0]  CMD_OP;
    logic [39:0] CMD_DATA;
    logic        CMD_ACK;
    logic        HALT;
    logic        STEP;
    logic        ERR_CSUM;
    logic        ERR_TIMEOUT;

    jtag_cmd_rx #(
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .CLK_50      (CLK_50),
        .RESET       (RESET),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_READY    (RX_READY),
        .CMD_VALID   (CMD_VALID),
        .CMD_OP      (CMD_OP),
        .CMD_DATA    (CMD_DATA),
        .CMD_ACK     (CMD_ACK),
        .HALT        (HALT),
        .STEP        (STEP),
        .ERR_CSUM    (ERR_CSUM),
        .ERR_TIMEOUT (ERR_TIMEOUT)
    );

    initial begin
        CLK_50 = 1'b0;
        forever #5 CLK_50 = ~CLK_50;
    end

    typedef enum logic [2:0] {EV_CMD, EV_HALT, EV_STEP, EV_CSUM, EV_TMO} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  op;
        logic [39:0] data;
        logic        halt;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] op,
                             input logic [39:0] data, input logic halt);
        ev_t e;
        e.kind = k;
        e.op   = op;
        e.data = data;
        e.halt = halt;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t g);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", g.kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(g.kind), 64'(e.kind));
            if (e.kind == EV_CMD) begin
                check("cmd_op", 64'(g.op), 64'(e.op));
                check("cmd_data", 64'(g.data), 64'(e.data));
            end else if (e.kind == EV_HALT) begin
                check("halt_level", 64'(g.halt), 64'(e.halt));
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and compares against the queue.
    logic cmd_valid_q = 1'b0;
    logic halt_q      = 1'b0;

    always @(negedge CLK_50) begin
        ev_t g;
        if (mon_en) begin
            g.op   = CMD_OP;
            g.data = CMD_DATA;
            g.halt = HALT;
            if (CMD_VALID === 1'b1 && !cmd_valid_q) begin
                g.kind = EV_CMD;
                observe(g);
            end
            if (HALT !== halt_q) begin
                g.kind = EV_HALT;
                observe(g);
            end
            if (STEP === 1'b1) begin
                g.kind = EV_STEP;
                observe(g);
            end
            if (ERR_CSUM === 1'b1) begin
                g.kind = EV_CSUM;
                observe(g);
            end
            if (ERR_TIMEOUT === 1'b1) begin
                g.kind = EV_TMO;
                observe(g);
            end
            cmd_valid_q <= CMD_VALID;
            halt_q      <= HALT;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (RX_READY !== 1'b1 && waited < 50) begin
            RX_VALID = 1'b0;
            @(negedge CLK_50);
            waited++;
        end
        if (RX_READY !== 1'b1) begin
            check("rx_ready_wait", 64'(RX_READY), 64'd1);
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK_50);
        RX_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) begin
            send_byte(f[i*8 +: 8]);
        end
    endtask

    task automatic ack_cmd();
        CMD_ACK = 1'b1;
        @(negedge CLK_50);
        CMD_ACK = 1'b0;
        check("ack_valid_low", 64'(CMD_VALID), 64'd0);
        check("ack_ready_high", 64'(RX_READY), 64'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET    = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        CMD_ACK  = 1'b0;
        repeat (2) @(negedge CLK_50);
        RESET = 1'b0;
        @(negedge CLK_50);

        check("rst_rx_ready", 64'(RX_READY), 64'd1);
        check("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
        check("rst_cmd_op", 64'(CMD_OP), 64'h0);
        check("rst_cmd_data", 64'(CMD_DATA), 64'h0);
        check("rst_halt", 64'(HALT), 64'd0);
        check("rst_pulses", 64'({STEP, ERR_CSUM, ERR_TIMEOUT}), 64'd0);
        mon_en = 1'b1;

        // Good command, ACK held off for a few cycles.
        expect_ev(EV_CMD, 8'h10, 40'h0000000100, 1'b0);
        send_frame(64'hA5_10_00_01_00_00_00_11);
        check("cmd_valid_latency", 64'(CMD_VALID), 64'd1);
        check("cmd_ready_low", 64'(RX_READY), 64'd0);
        repeat (3) @(negedge CLK_50);
        check("cmd_valid_held", 64'(CMD_VALID), 64'd1);
        check("cmd_op_stable", 64'(CMD_OP), 64'h10);
        check("cmd_data_stable", 64'(CMD_DATA), 64'h0000000100);
        ack_cmd();

        // Halt set, with ACK asserted outside PEND (must be ignored).
        CMD_ACK = 1'b1;
        expect_ev(EV_HALT, 8'h00, 40'h0, 1'b1);
        send_frame(64'hA5_01_01_00_00_00_00_00);
        CMD_ACK = 1'b0;
        check("halt_set", 64'(HALT), 64'd1);
        check("halt_no_cmd", 64'(CMD_VALID), 64'd0);

        expect_ev(EV_STEP, 8'h00, 40'h0, 1'b0);
        send_frame(64'hA5_02_00_00_00_00_00_02);
        check("step_pulse", 64'(STEP), 64'd1);

        expect_ev(EV_HALT, 8'h00, 40'h0, 1'b0);
        send_frame(64'hA5_01_00_00_00_00_00_01);
        check("halt_clear", 64'(HALT), 64'd0);

        // Checksum error followed back-to-back by a good frame, ACK in first valid cycle.
        expect_ev(EV_CSUM, 8'h00, 40'h0, 1'b0);
        send_frame(64'hA5_20_FF_00_00_00_00_00);
        check("csum_pulse", 64'(ERR_CSUM), 64'd1);
        check("csum_no_cmd", 64'(CMD_VALID), 64'd0);
        expect_ev(EV_CMD, 8'h10, 40'h0000000100, 1'b0);
        send_frame(64'hA5_10_00_01_00_00_00_11);
        check("after_err_valid", 64'(CMD_VALID), 64'd1);
        ack_cmd();

        // Sync hunt with garbage and in-frame sync bytes.
        expect_ev(EV_CMD, 8'h30, 40'h000000A5A5, 1'b0);
        send_byte(8'h33);
        send_byte(8'h7E);
        send_frame(64'hA5_30_A5_A5_00_00_00_30);
        check("hunt_valid", 64'(CMD_VALID), 64'd1);
        ack_cmd();

        // Inter-byte timeout: 16 idle cycles after the last accepted byte.
        expect_ev(EV_TMO, 8'h00, 40'h0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h11);
        repeat (15) @(negedge CLK_50);
        check("tmo_not_early", 64'(ERR_TIMEOUT), 64'd0);
        @(negedge CLK_50);
        check("tmo_pulse", 64'(ERR_TIMEOUT), 64'd1);
        check("tmo_cmd_op_kept", 64'(CMD_OP), 64'h30);
        check("tmo_cmd_valid", 64'(CMD_VALID), 64'd0);
        expect_ev(EV_CMD, 8'h40, 40'h0, 1'b0);
        send_frame(64'hA5_40_00_00_00_00_00_40);
        check("tmo_next_data", 64'(CMD_DATA), 64'h0);
        ack_cmd();

        // Reset while a command is pending and HALT is set.
        expect_ev(EV_HALT, 8'h00, 40'h0, 1'b1);
        send_frame(64'hA5_01_01_00_00_00_00_00);
        expect_ev(EV_CMD, 8'h10, 40'h0000000100, 1'b0);
        send_frame(64'hA5_10_00_01_00_00_00_11);
        check("pend_valid", 64'(CMD_VALID), 64'd1);
        expect_ev(EV_HALT, 8'h00, 40'h0, 1'b0);
        RESET = 1'b1;
        @(negedge CLK_50);
        RESET = 1'b0;
        check("prst_cmd_valid", 64'(CMD_VALID), 64'd0);
        check("prst_halt", 64'(HALT), 64'd0);
        check("prst_rx_ready", 64'(RX_READY), 64'd1);
        check("prst_cmd_data", 64'(CMD_DATA), 64'h0);

        repeat (3) @(negedge CLK_50);
        check("events_outstanding", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
